branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Direct-mapped branch target buffer with 2-bit saturating counters.
//  Drives take_branch/branch_predict into the program counter every cycle, looked up by the current pc.
//  Trained by the execute stage when a conditional branch resolves.
//  Sits between fetch (pc) and execute (branch resolution).
// PARAMETERS
//  ENTRIES  16           number of BTB entries, power of 2, >=2
//  ADDR_W   `ADDR_WIDTH  instruction address width
//  INDEX_W  $clog2(ENTRIES)  derived, not overridden
//  TAG_W    ADDR_W-INDEX_W-1  derived; pc[0] always 0 (pc steps by 2)
// PORTS
//  clk               in   1        clock
//  reset             in   1        synchronous, active-high
//  pc                in   ADDR_W   current fetch address
//  lookup_en         in   1        fetch holds a branch opcode and is not stalled (stats only)
//  take_branch       out  1        predict taken for pc
//  branch_predict    out  ADDR_W   predicted target (0 when take_branch=0)
//  ready             out  1        init sweep done, predictions valid
//  update_valid      in   1        execute resolved a conditional branch this cycle
//  update_pc         in   ADDR_W   address of the resolved branch
//  update_taken      in   1        actual outcome
//  update_target     in   ADDR_W   actual target (valid when update_taken)
//  stat_lookups      out  32       [BTB_STATS_EN only]
//  stat_hits         out  32       [BTB_STATS_EN only]
//  stat_updates      out  32       [BTB_STATS_EN only]
//  stat_allocs       out  32       [BTB_STATS_EN only]
// BEHAVIOUR
//  Entry: valid, tag, target[ADDR_W], ctr[1:0] (00 SNT, 01 WNT, 10 WT, 11 ST).
//  index = addr[INDEX_W:1]; tag = addr[ADDR_W-1:INDEX_W+1].
//  FSM: INIT -> RUN.
//   reset=1: state<=INIT, ptr<=0, ready<=0, stats<=0; array not written on reset cycle.
//   INIT: each cycle valid[ptr]<=0, ctr[ptr]<=01, ptr<=ptr+1; at ptr==ENTRIES-1 -> RUN, ready<=1.
//     INIT lasts exactly ENTRIES cycles after reset deasserts.
//   Updates are dropped in INIT.
//  Lookup is combinational, 0-cycle latency.
//   In RUN: take_branch = valid[idx] && tag match && ctr[idx][1]; branch_predict = target[idx] else 0.
//   In INIT: take_branch=0, branch_predict=0.
//  Update is registered, visible to lookup on the next cycle (no same-cycle bypass).
//   Hit (valid, tag match):
//     ctr saturating +1 on taken, -1 on not-taken; 11+taken stays 11, 00+not-taken stays 00.
//     On taken: target <= update_target.
//   Miss & taken: allocate/overwrite entry: valid=1, tag, target, ctr=10.
//   Miss & not-taken: no change.
//  Same-cycle lookup and update on the same index: lookup sees old state.
//  Reset mid-INIT restarts the sweep at ptr=0; reset in RUN re-enters INIT.
//  The array has no reset value other than via the sweep.
// CONFIGURATION
//  BTB_STATS_EN defined: four 32-bit wrapping counters, cleared by reset, counting only in RUN:
//   lookups (lookup_en), hits (lookup_en && take_branch), updates (update_valid), allocs (miss & taken).
//  BTB_STATS_EN undefined: stat_* ports and counters absent; all other behaviour identical.
// STRUCTURE
//  defines.vh: BTB_CTR_SNT/WNT/WT/ST 2-bit constants, BTB_ST_INIT/BTB_ST_RUN state encodings.
//  One sub-module, btb_sat_counter: combinational 2-bit saturating next-value (ctr, taken) -> ctr_next.
//  Array in flat regs indexed by INDEX_W; no memory macro.
// TESTING
//  Init: reset 1 cycle, ENTRIES=16 -> ready=0 for 16 cycles, ready=1 on cycle 17, take_branch=0 throughout.
//  Alloc: update pc=0x0010 taken target=0x0040 -> next cycle pc=0x0010 gives take_branch=1, predict=0x0040.
//  Hysteresis: after alloc (10), one not-taken -> 01, take_branch=0; two taken -> 11; one not-taken -> 10, still taken.
//  Aliasing: alloc 0x0010, then alloc 0x0030 taken (same index, ENTRIES=16) -> pc=0x0010 misses (take_branch=0).
//  Miss not-taken: update pc=0x0052 not-taken on empty entry -> entry stays invalid; stat_allocs unchanged.
//  Reset mid-INIT at cycle 5 -> ready rises exactly 16 cycles after reset deasserts; stats read 0 (BTB_STATS_EN).

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// Shared constants for the branch target predictor: counter encodings, FSM states,
// the saturating-counter step function and the statistics record.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package branch_target_predictor_pkg;

  typedef logic [1:0] btb_ctr_t;

  localparam btb_ctr_t BTB_CTR_SNT = 2'b00;
  localparam btb_ctr_t BTB_CTR_WNT = 2'b01;
  localparam btb_ctr_t BTB_CTR_WT  = 2'b10;
  localparam btb_ctr_t BTB_CTR_ST  = 2'b11;

  localparam logic [0:0] BTB_ST_INIT = 1'b0;
  localparam logic [0:0] BTB_ST_RUN  = 1'b1;

  localparam int BTB_DEFAULT_ADDR_W = `ADDR_WIDTH;

  typedef struct packed {
    logic [31:0] lookups;
    logic [31:0] hits;
    logic [31:0] updates;
    logic [31:0] allocs;
  } btb_stats_t;

  // Saturates at both ends: strongly-taken stays put on taken, strongly-not-taken on not-taken.
  function automatic btb_ctr_t btb_ctr_step(input btb_ctr_t ctr, input logic taken);
    btb_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != BTB_CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != BTB_CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_target_predictor_btb_sat_counter.sv
// Combinational 2-bit saturating counter next-value for the branch target predictor.
module btb_sat_counter
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  assign ctr_next = btb_ctr_step(ctr, taken);

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, combinational lookup and registered update.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter  int ENTRIES = 16,
  parameter  int ADDR_W  = BTB_DEFAULT_ADDR_W,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = ADDR_W - INDEX_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              lookup_en,
  output logic              take_branch,
  output logic [ADDR_W-1:0] branch_predict,
  output logic              ready,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_allocs
`endif
);

  logic [0:0]         r_state;
  logic [INDEX_W-1:0] r_ptr;
  logic               r_ready;

  logic               r_valid  [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [ADDR_W-1:0]  r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic               w_run;
  logic [INDEX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;
  logic [INDEX_W-1:0] w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic [1:0]         w_up_ctr_next;
  logic               w_up_fire;
  logic               w_alloc;

  assign w_run = (r_state == BTB_ST_RUN);

  // Lookup path: pc[0] is always zero, so the index starts at bit 1.
  assign w_lk_idx       = pc[INDEX_W:1];
  assign w_lk_tag       = pc[ADDR_W-1:INDEX_W+1];
  assign w_lk_hit       = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign take_branch    = w_run && w_lk_hit && r_ctr[w_lk_idx][1];
  assign branch_predict = take_branch ? r_target[w_lk_idx] : '0;
  assign ready          = r_ready;

  assign w_up_idx  = update_pc[INDEX_W:1];
  assign w_up_tag  = update_pc[ADDR_W-1:INDEX_W+1];
  assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_fire = w_run && update_valid;
  assign w_alloc   = w_up_fire && !w_up_hit && update_taken;

  btb_sat_counter u_sat_counter (
    .ctr      (r_ctr[w_up_idx]),
    .taken    (update_taken),
    .ctr_next (w_up_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BTB_ST_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == BTB_ST_INIT) begin
      r_ptr <= r_ptr + INDEX_W'(1);
      if (r_ptr == INDEX_W'(ENTRIES - 1)) begin
        r_state <= BTB_ST_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // Entry storage has no reset; the init sweep is the only way entries get cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_run) begin
        r_valid[r_ptr] <= 1'b0;
        r_ctr[r_ptr]   <= BTB_CTR_WNT;
      end else if (w_up_fire) begin
        if (w_up_hit) begin
          r_ctr[w_up_idx] <= w_up_ctr_next;
          if (update_taken) r_target[w_up_idx] <= update_target;
        end else if (update_taken) begin
          r_valid[w_up_idx]  <= 1'b1;
          r_tag[w_up_idx]    <= w_up_tag;
          r_target[w_up_idx] <= update_target;
          r_ctr[w_up_idx]    <= BTB_CTR_WT;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  btb_stats_t r_stats;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stats <= '0;
    end else if (w_run) begin
      if (lookup_en)                r_stats.lookups <= r_stats.lookups + 32'd1;
      if (lookup_en && take_branch) r_stats.hits    <= r_stats.hits + 32'd1;
      if (update_valid)             r_stats.updates <= r_stats.updates + 32'd1;
      if (w_alloc)                  r_stats.allocs  <= r_stats.allocs + 32'd1;
    end
  end

  assign stat_lookups = r_stats.lookups;
  assign stat_hits    = r_stats.hits;
  assign stat_updates = r_stats.updates;
  assign stat_allocs  = r_stats.allocs;

  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, pc[0], update_pc[0]};
`else
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, pc[0], update_pc[0], lookup_en, w_alloc};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized self-checking bench for branch_target_predictor against a behavioural BTB model,
// plus directed literal checks of init timing, allocation, hysteresis and aliasing.
module tb_branch_target_predictor;

  localparam int ENTRIES = 16;
  localparam int AW      = 16;
  localparam int IW      = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          lookup_en = 1'b0;
  logic          take_branch;
  logic [AW-1:0] branch_predict;
  logic          ready;
  logic          update_valid = 1'b0;
  logic [AW-1:0] update_pc = '0;
  logic          update_taken = 1'b0;
  logic [AW-1:0] update_target = '0;
`ifdef BTB_STATS_EN
  logic [31:0]   stat_lookups, stat_hits, stat_updates, stat_allocs;
`endif

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(ENTRIES), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .lookup_en      (lookup_en),
    .take_branch    (take_branch),
    .branch_predict (branch_predict),
    .ready          (ready),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups   (stat_lookups),
    .stat_hits      (stat_hits),
    .stat_updates   (stat_updates),
    .stat_allocs    (stat_allocs)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit started = 1'b0;

  // Behavioural model: one record per entry, plus a count of init cycles seen.
  bit          m_run = 1'b0;
  int          m_cnt = 0;
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_lookups = 0, m_hits = 0, m_updates = 0, m_allocs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      int idx, tag, ui, ut;
      bit exp_take;
      int exp_pred;
      idx = (int'(pc) >> 1) % ENTRIES;
      tag = int'(pc) >> (IW + 1);
      exp_take = m_run && m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
      exp_pred = exp_take ? m_tgt[idx] : 0;
      check("take_branch", 32'(take_branch), 32'(exp_take));
      check("branch_predict", 32'(branch_predict), 32'(exp_pred));
      check("ready", 32'(ready), 32'(m_run));
`ifdef BTB_STATS_EN
      check("stat_lookups", stat_lookups, m_lookups);
      check("stat_hits", stat_hits, m_hits);
      check("stat_updates", stat_updates, m_updates);
      check("stat_allocs", stat_allocs, m_allocs);
`endif
      if (reset) begin
        m_run = 1'b0;
        m_cnt = 0;
        m_lookups = 0; m_hits = 0; m_updates = 0; m_allocs = 0;
      end else if (!m_run) begin
        m_cnt++;
        if (m_cnt == ENTRIES) begin
          m_run = 1'b1;
          for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
          end
        end
      end else begin
        if (lookup_en) m_lookups++;
        if (lookup_en && exp_take) m_hits++;
        if (update_valid) begin
          m_updates++;
          ui = (int'(update_pc) >> 1) % ENTRIES;
          ut = int'(update_pc) >> (IW + 1);
          $display("upd pc=0x%04h taken=%0d target=0x%04h", update_pc, update_taken, update_target);
          if (m_valid[ui] && m_tag[ui] == ut) begin
            if (update_taken) begin
              m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
              m_tgt[ui] = int'(update_target);
            end else begin
              m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
          end else if (update_taken) begin
            m_valid[ui] = 1'b1;
            m_tag[ui]   = ut;
            m_tgt[ui]   = int'(update_target);
            m_ctr[ui]   = 2;
            m_allocs++;
          end
        end
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge, return just after the following falling edge.
  task automatic step(input bit rst, input logic [AW-1:0] a_pc, input bit uv,
                      input logic [AW-1:0] upc, input bit ut, input logic [AW-1:0] utgt);
    @(posedge clk);
    #1;
    reset         = rst;
    pc            = a_pc;
    lookup_en     = 1'b1;
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    started = 1'b1;

    // Init timing: ready low for 16 cycles, high on the 17th.
    for (int i = 1; i <= 17; i++) begin
      step(0, 16'h0010, 0, 16'h0, 0, 16'h0);
      check("init_ready", 32'(ready), (i == 17) ? 32'd1 : 32'd0);
      check("init_take", 32'(take_branch), 32'd0);
    end

    // Allocation.
    step(0, 16'h0010, 1, 16'h0010, 1, 16'h0040);
    step(0, 16'h0010, 0, 16'h0, 0, 16'h0);
    check("alloc_take", 32'(take_branch), 32'd1);
    check("alloc_pred", 32'(branch_predict), 32'h0040);

    // Hysteresis: 10 -NT-> 01 -T-> 10 -T-> 11 -NT-> 10.
    step(0, 16'h0010, 1, 16'h0010, 0, 16'h0);
    check("hyst_wt", 32'(take_branch), 32'd1);
    step(0, 16'h0010, 1, 16'h0010, 1, 16'h0040);
    check("hyst_wnt", 32'(take_branch), 32'd0);
    check("hyst_wnt_pred", 32'(branch_predict), 32'h0);
    step(0, 16'h0010, 1, 16'h0010, 1, 16'h0040);
    check("hyst_wt2", 32'(take_branch), 32'd1);
    step(0, 16'h0010, 1, 16'h0010, 0, 16'h0);
    check("hyst_st", 32'(take_branch), 32'd1);
    step(0, 16'h0010, 0, 16'h0, 0, 16'h0);
    check("hyst_back_wt", 32'(take_branch), 32'd1);
    check("hyst_pred", 32'(branch_predict), 32'h0040);

    // Aliasing: 0x0030 shares index 8 with 0x0010.
    step(0, 16'h0030, 1, 16'h0030, 1, 16'h0080);
    check("alias_pre", 32'(take_branch), 32'd0);
    step(0, 16'h0010, 0, 16'h0, 0, 16'h0);
    check("alias_old_miss", 32'(take_branch), 32'd0);
    step(0, 16'h0030, 0, 16'h0, 0, 16'h0);
    check("alias_new_take", 32'(take_branch), 32'd1);
    check("alias_new_pred", 32'(branch_predict), 32'h0080);

    // Miss and not-taken leaves the entry invalid.
    step(0, 16'h0052, 1, 16'h0052, 0, 16'h0);
    step(0, 16'h0052, 0, 16'h0, 0, 16'h0);
    check("miss_nt_take", 32'(take_branch), 32'd0);
`ifdef BTB_STATS_EN
    check("miss_nt_allocs", stat_allocs, 32'd2);
    check("miss_nt_updates", stat_updates, 32'd7);
`endif

    // Reset re-asserted on the fifth init cycle restarts the 16-cycle sweep.
    step(1, 16'h0030, 0, 16'h0, 0, 16'h0);
    for (int i = 1; i <= 4; i++) step(0, 16'h0030, 0, 16'h0, 0, 16'h0);
    step(1, 16'h0030, 0, 16'h0, 0, 16'h0);
    for (int i = 1; i <= 17; i++) begin
      step(0, 16'h0030, 1, 16'h0030, 1, 16'h0090);
      check("reinit_ready", 32'(ready), (i == 17) ? 32'd1 : 32'd0);
`ifdef BTB_STATS_EN
      if (i == 1) check("reinit_stats", stat_lookups | stat_updates | stat_allocs, 32'd0);
`endif
    end
    check("reinit_cleared", 32'(take_branch), 32'd0);

    // Random traffic over a small set of tags so hits, aliasing and saturation all occur.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] rpc, upc, tgt;
      rpc = AW'(($urandom_range(0, 3) << (IW + 1)) | ($urandom_range(0, ENTRIES - 1) << 1));
      upc = AW'(($urandom_range(0, 3) << (IW + 1)) | ($urandom_range(0, ENTRIES - 1) << 1));
      tgt = AW'($urandom) & ~AW'(1);
      step(($urandom_range(0, 399) == 0), rpc, ($urandom_range(0, 1) == 1), upc,
           ($urandom_range(0, 2) != 0), tgt);
      lookup_en = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk);
    #1;
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
